// File: rtl/multi_ch_cmd_decoder_pkg.sv
// Shared constants and types for the multi-channel command decoder.
// Command bytes, error codes, FSM states and the byte-count helper.
package cmd_decoder_pkg;

    localparam logic [7:0] CMD_DATA = 8'hA1;
    localparam logic [7:0] CMD_FREQ = 8'hA2;
    localparam logic [7:0] CMD_STOP = 8'hA3;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_CMD    = 3'd1,
        ERR_BAD_CHK    = 3'd2,
        ERR_BAD_CH     = 3'd3,
        ERR_BAD_PERIOD = 3'd4,
        ERR_TIMEOUT    = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    function automatic int pack_num(input int data_bit);
        return data_bit / 8;
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_DATA) || (b == CMD_FREQ) || (b == CMD_STOP);
    endfunction

endpackage

// File: rtl/multi_ch_cmd_decoder_if.sv
// Byte stream from the UART receiver into the command decoder.
// The receiver drives the master side, the decoder listens on slave.
interface multi_ch_cmd_decoder_if;

    logic [7:0] data_i;
    logic       rx_done_tick_i;

    modport master (output data_i, rx_done_tick_i);
    modport slave  (input  data_i, rx_done_tick_i);

endinterface

// File: rtl/multi_ch_cmd_decoder_gap_timer.sv
// Inter-byte gap counter; saturates at TIMEOUT_CYC and flags it.
// Clear has priority over enable.
module gap_timer #(
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == W'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_ch_cmd_decoder.sv
// Assembles UART bytes into DATA / FREQ / STOP_ALL packets, validates
// them and commits the fields to the pattern-generator outputs.
module multi_ch_cmd_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int         DATA_BIT    = 32,
    parameter int         CH_NUM      = 16,
    parameter int         TIMEOUT_CYC = 10000,
    parameter logic [7:0] SLOW_RST    = 8'h14,
    parameter logic [7:0] FAST_RST    = 8'h05,
    localparam int        CH_W        = $clog2(CH_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    multi_ch_cmd_decoder_if.slave rx_i,
    output logic [DATA_BIT-1:0]   output_pattern_o,
    output logic [DATA_BIT-1:0]   freq_pattern_o,
    output logic [CH_W-1:0]       sel_out_o,
    output logic                  mode_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic [7:0]            slow_period_o,
    output logic [7:0]            fast_period_o,
    output logic [7:0]            cmd_o,
    output logic                  done_tick_o,
    output logic                  err_tick_o,
    output logic [2:0]            err_code_o
);

    localparam int PACK_NUM = pack_num(DATA_BIT);
    localparam int CNT_W    = $clog2(PACK_NUM + 3);

    localparam logic [CNT_W-1:0] LEN_DATA = CNT_W'(PACK_NUM + 1);
    localparam logic [CNT_W-1:0] LEN_FREQ = CNT_W'(PACK_NUM + 2);
    localparam logic [CNT_W-1:0] IDX_AUX  = CNT_W'(PACK_NUM);
    localparam logic [CH_W-1:0]  SEL_STOP = CH_W'(CH_NUM - 1);

    logic       tick;
    logic [7:0] rx_byte;
    logic       tmo;
    logic       discard;
    logic       ch_ok;

    state_e state_q, state_d;

    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          xor_q, xor_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    plen;
    logic [DATA_BIT-1:0] pat_q, pat_d;
    // Control byte minus its reserved bit: {channel, mode, stop, start}
    logic [6:0]          ctrl_q, ctrl_d;
    logic [7:0]          slow_q, slow_d;
    logic [7:0]          fast_q, fast_d;

    logic [DATA_BIT-1:0] opat_q, opat_d;
    logic [DATA_BIT-1:0] fpat_q, fpat_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                mode_q, mode_d;
    logic                start_q, start_d;
    logic                stop_q, stop_d;
    logic [7:0]          slowp_q, slowp_d;
    logic [7:0]          fastp_q, fastp_d;
    logic [7:0]          cmdo_q, cmdo_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    err_e                ecode_q, ecode_d;

    assign tick    = rx_i.rx_done_tick_i;
    assign rx_byte = rx_i.data_i;
    assign ch_ok   = int'(ctrl_q[6:3]) < CH_NUM;

    gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .clr_i (tick || (state_q == ST_IDLE)),
        .en_i  (state_q != ST_IDLE),
        .tc_o  (tmo)
    );

    always_comb begin
        plen = '0;
        unique case (1'b1)
            (cmd_q == CMD_DATA): plen = LEN_DATA;
            (cmd_q == CMD_FREQ): plen = LEN_FREQ;
            default:             plen = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tick always wins over a timeout expiring on the same edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick && is_cmd(rx_byte)) begin
                    state_d = (rx_byte == CMD_STOP) ? ST_CHECK
                                                    : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (tick) begin
                    if (cnt_q == plen - CNT_W'(1)) state_d = ST_CHECK;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (tick || tmo) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d   = cmd_q;
        xor_d   = xor_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        ctrl_d  = ctrl_q;
        slow_d  = slow_q;
        fast_d  = fast_q;
        opat_d  = opat_q;
        fpat_d  = fpat_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        slowp_d = slowp_q;
        fastp_d = fastp_q;
        cmdo_d  = cmdo_q;
        ecode_d = ecode_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    if (is_cmd(rx_byte)) begin
                        cmd_d   = rx_byte;
                        xor_d   = rx_byte;
                        cnt_d   = '0;
                        discard = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = ERR_BAD_CMD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (tick) begin
                    xor_d = xor_q ^ rx_byte;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < IDX_AUX) begin
                        pat_d = (pat_q >> 8)
                              | (DATA_BIT'(rx_byte) << (DATA_BIT - 8));
                    end else if (cnt_q == IDX_AUX) begin
                        if (cmd_q == CMD_DATA) begin
                            ctrl_d = {rx_byte[7:4], rx_byte[2:0]};
                        end else begin
                            slow_d = rx_byte;
                        end
                    end else begin
                        fast_d = rx_byte;
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                    discard = 1'b1;
                end
            end
            ST_CHECK: begin
                if (tick) begin
                    discard = 1'b1;
                    if (rx_byte != xor_q) begin
                        err_d   = 1'b1;
                        ecode_d = ERR_BAD_CHK;
                    end else if (cmd_q == CMD_DATA && !ch_ok) begin
                        err_d   = 1'b1;
                        ecode_d = ERR_BAD_CH;
                    end else if (cmd_q == CMD_FREQ &&
                                 (slow_q == '0 || fast_q == '0)) begin
                        err_d   = 1'b1;
                        ecode_d = ERR_BAD_PERIOD;
                    end else begin
                        done_d = 1'b1;
                        cmdo_d = cmd_q;
                        unique case (1'b1)
                            (cmd_q == CMD_DATA): begin
                                opat_d  = pat_q;
                                sel_d   = ctrl_q[3 +: CH_W];
                                mode_d  = ctrl_q[2];
                                stop_d  = ctrl_q[1];
                                start_d = ctrl_q[0] & ~ctrl_q[1];
                            end
                            (cmd_q == CMD_FREQ): begin
                                fpat_d  = pat_q;
                                slowp_d = slow_q;
                                fastp_d = fast_q;
                            end
                            default: begin
                                stop_d = 1'b1;
                                sel_d  = SEL_STOP;
                            end
                        endcase
                    end
                end else if (tmo) begin
                    err_d   = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                    discard = 1'b1;
                end
            end
            default: ;
        endcase
        if (discard) begin
            pat_d  = '0;
            ctrl_d = '0;
            slow_d = '0;
            fast_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            cmd_q   <= '0;
            xor_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            ctrl_q  <= '0;
            slow_q  <= '0;
            fast_q  <= '0;
            opat_q  <= '0;
            fpat_q  <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            slowp_q <= SLOW_RST;
            fastp_q <= FAST_RST;
            cmdo_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            cmd_q   <= cmd_d;
            xor_q   <= xor_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            ctrl_q  <= ctrl_d;
            slow_q  <= slow_d;
            fast_q  <= fast_d;
            opat_q  <= opat_d;
            fpat_q  <= fpat_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            slowp_q <= slowp_d;
            fastp_q <= fastp_d;
            cmdo_q  <= cmdo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    assign output_pattern_o = opat_q;
    assign freq_pattern_o   = fpat_q;
    assign sel_out_o        = sel_q;
    assign mode_o           = mode_q;
    assign start_o          = start_q;
    assign stop_o           = stop_q;
    assign slow_period_o    = slowp_q;
    assign fast_period_o    = fastp_q;
    assign cmd_o            = cmdo_q;
    assign done_tick_o      = done_q;
    assign err_tick_o       = err_q;
    assign err_code_o       = ecode_q;

endmodule
